// File: rtl/mem_6502_pkg.sv
// Shared types for the 6502 memory path: address width, address type and
// the write-combining buffer state encoding.
package mem_6502_pkg;

    localparam int MEM_AW = 24;

    typedef logic [MEM_AW-1:0] mem_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2,
        PASS  = 2'd3
    } wbuf_state_t;

    // A single-byte write that may be merged: a write that is not part of a burst.
    function automatic logic is_plain_write(input logic wr, input logic wburst);
        return wr & ~wburst;
    endfunction

endpackage

// File: rtl/mem_wbuf_6502.sv
// Write-combining buffer between cache_6502 (u_*) and spi_sram_master (d_*).
// Address-contiguous single-byte writes are collected and sent as one write
// burst; reads and upstream bursts pass straight through once the buffer is
// empty, so the SRAM always sees program order.
// Optional feature macro: WBUF_IDLE_FLUSH_EN (auto-flush after IDLE_CYCLES
// cycles without a buffered write).
//
// Handshake (both sides): a request is valid while *_en=1 and its fields are
// held stable until *_rdy=1; the beat completes in the cycle *_en & *_rdy.
module mem_wbuf_6502
    import mem_6502_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int IDLE_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  mem_addr_t               u_addr,
    input  logic                    u_en,
    input  logic                    u_wr,
    input  logic                    u_rburst,
    input  logic                    u_wburst,
    input  logic [7:0]              u_wdata,
    output logic                    u_rdy,
    output logic [7:0]              u_rdata,
    output logic [7:0]              u_rdata0,
    output logic                    u_rdata_load,
    output mem_addr_t               d_addr,
    output logic                    d_en,
    output logic                    d_wr,
    output logic                    d_rburst,
    output logic                    d_wburst,
    output logic [7:0]              d_wdata,
    input  logic                    d_rdy,
    input  logic [7:0]              d_rdata,
    input  logic [7:0]              d_rdata0,
    input  logic                    d_rdata_load,
    output wbuf_state_t             o_dbg_state,
    output logic [$clog2(DEPTH):0]  o_dbg_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    // Elaboration-time sanity checks on the configuration.
    if (DEPTH < 2 || DEPTH > 32 || (1 << IW) != DEPTH) begin : g_bad_depth
        $error("mem_wbuf_6502: DEPTH must be a power of 2 in 2..32");
    end
    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("mem_wbuf_6502: IDLE_CYCLES must be at least 1");
    end

    wbuf_state_t     r_state;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_k;
    mem_addr_t       r_base;
    logic [7:0]      r_buf [DEPTH];

`ifdef WBUF_IDLE_FLUSH_EN
    localparam int DW = $clog2(IDLE_CYCLES + 1);
    logic [DW-1:0]   r_idle;
`endif

    logic            w_plain_wr;
    mem_addr_t       w_next_addr;
    logic            w_contig;
    logic            w_last_beat;
    logic            w_burst_end;
    logic            w_store;
    logic [IW-1:0]   w_wr_idx;

    assign w_plain_wr  = is_plain_write(u_wr, u_wburst);
    assign w_next_addr = r_base + mem_addr_t'(r_cnt);
    assign w_contig    = u_en & w_plain_wr & (u_addr == w_next_addr) & (r_cnt < CW'(DEPTH));
    assign w_last_beat = ({1'b0, r_k} == (r_cnt - CW'(1)));
    assign w_burst_end = ~u_rburst & ~u_wburst;

    // A byte enters the buffer either as the first byte (IDLE) or a contiguous follow-on (FILL).
    assign w_store  = ~rst & (((r_state == IDLE) & u_en & w_plain_wr) |
                              ((r_state == FILL) & w_contig));
    assign w_wr_idx = (r_state == IDLE) ? '0 : r_cnt[IW-1:0];

    // Read return is a straight wire from the master; nothing is registered here.
    assign u_rdata      = d_rdata;
    assign u_rdata0     = d_rdata0;
    assign u_rdata_load = d_rdata_load;

    assign o_dbg_state = r_state;
    assign o_dbg_cnt   = r_cnt;

    // Downstream request and upstream ready: flush beats, pass-through, or quiet.
    always_comb begin
        d_en     = 1'b0;
        d_wr     = 1'b0;
        d_rburst = 1'b0;
        d_wburst = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        u_rdy    = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (u_en) begin
                        if (w_plain_wr) begin
                            u_rdy = 1'b1;
                        end else begin
                            // Buffer is empty, so a read or burst beat goes out this cycle.
                            d_en     = 1'b1;
                            d_wr     = u_wr;
                            d_rburst = u_rburst;
                            d_wburst = u_wburst;
                            d_addr   = u_addr;
                            d_wdata  = u_wdata;
                            u_rdy    = d_rdy;
                        end
                    end
                end
                FILL: begin
                    u_rdy = w_contig;
                end
                FLUSH: begin
                    d_en     = 1'b1;
                    d_wr     = 1'b1;
                    d_wburst = ~w_last_beat;
                    d_addr   = r_base + mem_addr_t'(r_k);
                    d_wdata  = r_buf[r_k];
                end
                PASS: begin
                    d_en     = u_en;
                    d_wr     = u_wr;
                    d_rburst = u_rburst;
                    d_wburst = u_wburst;
                    d_addr   = u_addr;
                    d_wdata  = u_wdata;
                    u_rdy    = d_rdy;
                end
                default: ;
            endcase
        end
    end

    // Byte storage; contents are don't-care while the count says the slot is empty.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_buf[w_wr_idx] <= u_wdata;
        end
    end

    // Buffer FSM: collect contiguous bytes, drain as one burst, or forward other traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_base  <= '0;
`ifdef WBUF_IDLE_FLUSH_EN
            r_idle  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (u_en) begin
                        if (w_plain_wr) begin
                            r_base  <= u_addr;
                            r_cnt   <= CW'(1);
                            r_state <= FILL;
`ifdef WBUF_IDLE_FLUSH_EN
                            r_idle  <= DW'(IDLE_CYCLES);
`endif
                        end else if (!(d_rdy && w_burst_end)) begin
                            r_state <= PASS;
                        end
                    end
                end
                FILL: begin
                    if (u_en) begin
                        if (w_contig) begin
                            r_cnt <= r_cnt + CW'(1);
`ifdef WBUF_IDLE_FLUSH_EN
                            r_idle <= DW'(IDLE_CYCLES);
`endif
                            // A full buffer drains before anything else is accepted.
                            if (r_cnt + CW'(1) == CW'(DEPTH)) begin
                                r_state <= FLUSH;
                            end
                        end else begin
                            // Request stays pending and is replayed from IDLE after the drain.
                            r_state <= FLUSH;
                        end
                    end
`ifdef WBUF_IDLE_FLUSH_EN
                    else begin
                        if (r_idle <= DW'(1)) begin
                            r_state <= FLUSH;
                        end else begin
                            r_idle <= r_idle - DW'(1);
                        end
                    end
`endif
                end
                FLUSH: begin
                    if (d_rdy) begin
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_k     <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_k <= r_k + IW'(1);
                        end
                    end
                end
                PASS: begin
                    if (u_en && d_rdy && w_burst_end) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
